// File: rtl/fact_bcd_converter_if.sv
// Handshake bundle between the factorial stage, the BCD converter and the display stage.
// With BCD_BLANK_EN defined the bundle also carries the leading-zero blank_mask.
interface fact_bcd_converter_if #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  busy;
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0]     blank_mask;

  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, busy, blank_mask
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, busy, blank_mask
  );
`else
  modport master (
    output in_valid, bin_in, out_ready,
    input  in_ready, out_valid, bcd_out, busy
  );

  modport slave (
    input  in_valid, bin_in, out_ready,
    output in_ready, out_valid, bcd_out, busy
  );
`endif
endinterface

// File: rtl/fact_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one shift-add-3 iteration per clock.
// Optional macro BCD_BLANK_EN adds a registered leading-zero blank_mask output.
module fact_bcd_converter #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input logic               clk,
  input logic               rst,
  fact_bcd_converter_if.slave bus
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int ACC_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [IN_W-1:0]   bin_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  bcd_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [ACC_W-1:0]       acc_adj;
  logic [ACC_W+IN_W-1:0]  shift_w;
  logic [ACC_W-1:0]       acc_shf;
  logic [IN_W-1:0]        bin_shf;

  // Add-3 correction on every digit in parallel; a digit is at most 9 here,
  // so the 4-bit sum never carries into its neighbour.
  always_comb begin
    // NOTE: give every combinational output a default first so no path leaves it unassigned (no latch).
    acc_adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      acc_adj[4*k +: 4] = (acc_q[4*k +: 4] >= 4'd5) ? (acc_q[4*k +: 4] + 4'd3)
                                                      : acc_q[4*k +: 4];
    end
  end

  always_comb begin
    shift_w = {acc_adj, bin_q} << 1;
    acc_shf = shift_w[ACC_W+IN_W-1:IN_W];
    bin_shf = shift_w[IN_W-1:0];
  end

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_d;
  logic [DIGITS-1:0] blank_q;
  logic              all_zero;

  // Bit k blanks digit k when it and every higher digit are zero; digit 0 always shows.
  always_comb begin
    blank_d  = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      all_zero   = all_zero & (acc_shf[4*k +: 4] == 4'd0);
      blank_d[k] = all_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q <= '0;
    end else if (state_q == SHIFT && cnt_q == CNT_W'(1)) begin
      blank_q <= blank_d;
    end
  end

  assign bus.blank_mask = blank_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state updates here use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bin_q       <= '0;
      acc_q       <= '0;
      bcd_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            bin_q      <= bus.bin_in;
            acc_q      <= '0;
            cnt_q      <= CNT_W'(IN_W);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end

        SHIFT: begin
          acc_q <= acc_shf;
          bin_q <= bin_shf;
          cnt_q <= cnt_q - CNT_W'(1);
          // The final iteration's result goes straight to the output register.
          if (cnt_q == CNT_W'(1)) begin
            bcd_q       <= acc_shf;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fact_bcd_converter.sv
// Self-checking bench for fact_bcd_converter: directed vector table, corner sequences
// and randomized values checked against a decimal-arithmetic reference model.
module tb_fact_bcd_converter;

  localparam int IN_W   = 16;
  localparam int DIGITS = 5;

  logic clk;
  logic rst;

  fact_bcd_converter_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

  fact_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [IN_W-1:0]     bin;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   mask;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: decimal digits by repeated division.
  function automatic logic [4*DIGITS-1:0] model_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] model_mask(input int unsigned v);
    logic [DIGITS-1:0] m;
    int ndig;
    ndig = 1;
    while (v >= 10) begin
      v = v / 10;
      ndig++;
    end
    m = '0;
    for (int k = 0; k < DIGITS; k++) m[k] = (k >= ndig);
    return m;
  endfunction

  // Called at a negedge while idle; returns at the negedge after the acceptance edge.
  task automatic send(input logic [IN_W-1:0] v);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.bin_in   = v;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("in_ready_low_after_accept", 32'(bus.in_ready), 32'd0);
  endtask

  task automatic wait_done(input string name, input logic [4*DIGITS-1:0] exp_bcd,
                           input logic [DIGITS-1:0] exp_mask);
    int   n;
    logic saw_ready;
    n = 0;
    saw_ready = 1'b0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      saw_ready = saw_ready | bus.in_ready;
      n++;
    end
    check({name, "_latency"}, 32'(n), 32'(IN_W));
    check({name, "_in_ready_held_low"}, 32'(saw_ready), 32'd0);
    check({name, "_bcd"}, 32'(bus.bcd_out), 32'(exp_bcd));
`ifdef BCD_BLANK_EN
    check({name, "_mask"}, 32'(bus.blank_mask), 32'(exp_mask));
`else
    if (exp_mask === 'x) $display("note: unknown mask for %s", name);
`endif
  endtask

  task automatic handshake(input int delay);
    logic [4*DIGITS-1:0] held;
    held = bus.bcd_out;
    repeat (delay) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("bcd_stable_before_handshake", 32'(bus.bcd_out), 32'(held));
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_after_handshake", 32'(bus.out_valid), 32'd0);
    check("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    vecs[0] = '{16'd5040,  20'h05040, 5'b10000};
    vecs[1] = '{16'd1,     20'h00001, 5'b11110};
    vecs[2] = '{16'd2,     20'h00002, 5'b11110};
    vecs[3] = '{16'd6,     20'h00006, 5'b11110};
    vecs[4] = '{16'd24,    20'h00024, 5'b11100};
    vecs[5] = '{16'd120,   20'h00120, 5'b11000};
    vecs[6] = '{16'd720,   20'h00720, 5'b11000};
    vecs[7] = '{16'd0,     20'h00000, 5'b11110};
    vecs[8] = '{16'd65535, 20'h65535, 5'b00000};

    bus.in_valid  = 1'b0;
    bus.bin_in    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_bcd", 32'(bus.bcd_out), 32'd0);
`ifdef BCD_BLANK_EN
    check("reset_mask", 32'(bus.blank_mask), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      send(vecs[i].bin);
      wait_done($sformatf("vec%0d", i), vecs[i].bcd, vecs[i].mask);
      handshake(0);
    end

    // Back-pressure: held result, ignored in_valid, no acceptance on the handshake edge.
    send(16'd720);
    wait_done("bp720", 20'h00720, 5'b11000);
    bus.in_valid = 1'b1;
    bus.bin_in   = 16'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_bcd", 32'(bus.bcd_out), 32'h00720);
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_handshake_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_handshake_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_not_accepted_same_edge", 32'(bus.busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_accepted_next_idle", 32'(bus.busy), 32'd1);
    wait_done("bp_next", 20'h00001, 5'b11110);
    handshake(0);

    // Reset after eight iterations of 5040.
    send(16'd5040);
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    check("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    check("midreset_bcd", 32'(bus.bcd_out), 32'd0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midreset_no_out_valid", 32'(bus.out_valid), 32'd0);
    send(16'd24);
    wait_done("post_reset_24", 20'h00024, 5'b11100);
    handshake(0);

    // Randomized values against the decimal model, with random consumer stall.
    for (int i = 0; i < 24; i++) begin
      int unsigned v;
      v = $urandom_range(0, 65535);
      send(16'(v));
      wait_done($sformatf("rand%0d_%0d", i, v), model_bcd(v), model_mask(v));
      handshake(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, tests run %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fact_bcd_converter.md
Name: fact_bcd_converter

Overview:
- Sequential binary-to-BCD converter using double-dabble (shift-add-3). Downstream of the factorial stage.
- Takes the 16-bit factorial result and produces packed BCD digits for the display/readout stage.
- One iteration per clock. Valid/ready handshake on both input and output.

Parameters:
- IN_W, 16, binary input width.
- DIGITS, 5, number of BCD output digits. Must satisfy 10^DIGITS > 2^IN_W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  bin_in is valid
- in_ready  output  1  converter can accept a new value
- bin_in  input  IN_W  unsigned binary value (factorial result)
- out_valid  output  1  bcd_out holds a completed conversion
- out_ready  input  1  consumer accepts bcd_out
- bcd_out  output  4*DIGITS  packed BCD; digit k at bits [4k+3:4k], digit 0 least significant
- busy  output  1  high while in SHIFT state

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, bcd_out=0, iteration counter=0, internal shift register=0.
- States and transitions:
  - IDLE: in_ready=1. On in_valid && in_ready: load bin_in into the binary shift register, clear the BCD accumulator, set counter=IN_W, go to SHIFT.
  - SHIFT: in_ready=0, busy=1. Each cycle:
    - every BCD digit >= 5 gets +3, all digits in parallel;
    - then shift the concatenated {BCD accumulator, binary register} left by 1;
    - decrement the counter.
    - When the counter reaches 1 and this iteration completes, latch the accumulator into bcd_out and go to DONE.
  - DONE: out_valid=1, in_ready=0. bcd_out holds stable until out_valid && out_ready. On that handshake: out_valid=0, go to IDLE.
- Latency: the acceptance edge is edge 0. out_valid rises after edge IN_W (16 cycles by default). Minimum input-to-input spacing is IN_W+2 cycles when out_ready is held high.
- Overlap: none. A new input is never accepted while SHIFT or DONE is pending. in_valid during those states is ignored; the upstream must hold it.
- Arithmetic: add-3 is 4-bit, no carry into the next digit (the digit is <= 9 before the add). Digit values are always 0..9.
- bcd_out register: changes only on the SHIFT->DONE transition. It holds the last result while in IDLE.
- Boundaries:
  - bin_in=0 produces all-zero BCD after the full IN_W cycles; there is no early exit.
  - bin_in=2^IN_W-1 must convert exactly.
- Reset during SHIFT or DONE: immediate return to the reset values. The partial conversion is discarded and no out_valid is produced.
- Simultaneous events:
  - in_valid arriving in the same cycle as the DONE handshake is not accepted that cycle. It is accepted in the following IDLE cycle.
  - out_ready asserted while in IDLE/SHIFT has no effect.

Optional Feature:
- Macro: BCD_BLANK_EN.
- Defined:
  - adds output blank_mask [DIGITS-1:0], registered together with bcd_out;
  - bit k=1 when digit k and all more-significant digits are zero;
  - bit 0 is always 0, so value 0 shows a single "0";
  - reset value is 0.
- Undefined: port and logic absent. The rest of the behaviour is identical.

Test Plan:
- Reset, then bin_in=5040 (7!) with in_valid pulse and out_ready=1 -> out_valid rises 16 cycles after acceptance, bcd_out=20'h05040, in_ready returns to 1 one cycle after the handshake.
- Sweep bin_in=1,2,6,24,120,720 -> bcd_out=20'h00001, 00002, 00006, 00024, 00120, 00720. No overlap; in_ready low between acceptance and output handshake.
- Boundaries: bin_in=0 -> 20'h00000. bin_in=65535 -> 20'h65535. Both take the full 16 cycles.
- Back-pressure: 720 converted, out_ready held low 5 cycles -> out_valid and bcd_out stable for those cycles, in_ready=0, extra in_valid ignored. Raise out_ready -> single handshake, then next input accepted.
- Assert rst at iteration 8 of converting 5040 -> out_valid=0, in_ready=1, bcd_out=0 immediately. Then 24 converts to 20'h00024 normally.
- With BCD_BLANK_EN: 24 -> blank_mask=5'b11100. 0 -> 5'b11110. 65535 -> 5'b00000.
